// File: rtl/easyobv_pkg.sv
// Shared types and constants for the easyobv AXI-Stream traffic sink.
package easyobv_pkg;

   typedef enum logic [1:0] {
      RM_ALWAYS = 2'd0,
      RM_LFSR   = 2'd1,
      RM_DUTY   = 2'd2,
      RM_NEVER  = 2'd3
   } ready_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_e;

   // x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/easyobv_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with the XOR of the tapped bits entering at bit 0.
module easyobv_lfsr16
   import easyobv_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED,
   parameter logic [15:0] TAPS = LFSR_TAPS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & TAPS)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/easyobv_axis_sink.sv
// AXI-Stream traffic sink: programmable backpressure, packet framing checks and statistics.
//
// state   | meaning
// ST_IDLE | between packets; the next accepted beat starts a packet
// ST_BODY | mid-packet; tracking length and idle cycles
module easyobv_axis_sink
   import easyobv_pkg::*;
#(
   parameter int unsigned DWIDTH        = 32,
   parameter int unsigned HAS_KEEP      = 0,
   parameter int unsigned HAS_LAST      = 0,
   parameter int unsigned MAX_PKT_BEATS = 1024,
   parameter int unsigned TIMEOUT_BITS  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DWIDTH-1:0]       s_tdata,
   input  logic                    s_tvalid,
   input  logic [DWIDTH/8-1:0]     s_tkeep,
   input  logic                    s_tlast,
   output logic                    s_tready,
   input  logic                    enable,
   input  logic                    clear,
   input  logic [1:0]              ready_mode,
   input  logic [7:0]              ready_thresh,
   input  logic [7:0]              on_cycles,
   input  logic [7:0]              off_cycles,
   input  logic [TIMEOUT_BITS-1:0] timeout_val,
   output logic [63:0]             beat_cnt,
   output logic [63:0]             pkt_cnt,
   output logic [63:0]             byte_cnt,
   output logic [63:0]             stall_cnt,
   output logic [31:0]             max_pkt_len,
   output logic                    frame_err,
   output logic                    timeout
);

   localparam int unsigned KEEP_W = DWIDTH / 8;

   logic [15:0] lfsr_val;
   logic        unused_sig;

   logic                    ready_q, ready_d;
   logic                    duty_on_q, duty_on_d;
   logic [7:0]              duty_cnt_q, duty_cnt_d;
   state_e                  state_q, state_d;
   logic [31:0]             len_q, len_d, len_inc;
   logic [TIMEOUT_BITS-1:0] idle_q, idle_d;
   logic [63:0]             beat_q, beat_d, pkt_q, pkt_d;
   logic [63:0]             byte_q, byte_d, stall_q, stall_d;
   logic [31:0]             max_q, max_d;
   logic                    frame_q, frame_d, timeout_q, timeout_d;

   logic        accept;
   logic        tlast_eff;
   logic [63:0] beat_bytes;

   easyobv_lfsr16 #(
      .SEED (LFSR_SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (1'b1),
      .lfsr  (lfsr_val)
   );

   assign unused_sig = ^{s_tdata, s_tkeep, s_tlast, lfsr_val[15:8]};

   assign accept    = s_tvalid && ready_q;
   assign tlast_eff = (HAS_LAST != 0) ? s_tlast : 1'b1;
   assign len_inc   = (len_q == '1) ? len_q : len_q + 32'd1;

   always_comb begin
      beat_bytes = 64'(KEEP_W);
      if (HAS_KEEP != 0) begin
         beat_bytes = '0;
         for (int i = 0; i < int'(KEEP_W); i++) beat_bytes = beat_bytes + 64'(s_tkeep[i]);
      end
   end

   // Duty counter free-runs in every mode so switching into mode 2 picks up a live pattern.
   always_comb begin
      duty_on_d  = duty_on_q;
      duty_cnt_d = duty_cnt_q + 8'd1;
      if (duty_on_q) begin
         if (duty_cnt_d >= on_cycles) begin
            duty_cnt_d = '0;
            duty_on_d  = 1'b0;
         end
      end else if (duty_cnt_d >= off_cycles) begin
         duty_cnt_d = '0;
         duty_on_d  = 1'b1;
      end
   end

   always_comb begin
      ready_d = 1'b0;
      if (enable) begin
         case (ready_mode_e'(ready_mode))
            RM_ALWAYS: ready_d = 1'b1;
            RM_LFSR:   ready_d = (lfsr_val[7:0] < ready_thresh);
            RM_DUTY: begin
               if (on_cycles == 8'd0)       ready_d = 1'b0;
               else if (off_cycles == 8'd0) ready_d = 1'b1;
               else                         ready_d = duty_on_q;
            end
            RM_NEVER:  ready_d = 1'b0;
            default:   ready_d = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idle_d    = idle_q;
      beat_d    = beat_q;
      pkt_d     = pkt_q;
      byte_d    = byte_q;
      stall_d   = stall_q;
      max_d     = max_q;
      frame_d   = frame_q;
      timeout_d = timeout_q;

      if (clear) begin
         state_d   = ST_IDLE;
         len_d     = '0;
         idle_d    = '0;
         beat_d    = '0;
         pkt_d     = '0;
         byte_d    = '0;
         stall_d   = '0;
         max_d     = '0;
         frame_d   = 1'b0;
         timeout_d = 1'b0;
      end else begin
         if (accept) begin
            beat_d = beat_q + 64'd1;
            byte_d = byte_q + beat_bytes;
         end
         if (s_tvalid && !ready_q) stall_d = stall_q + 64'd1;

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  idle_d = timeout_val;
                  if (tlast_eff) begin
                     pkt_d = pkt_q + 64'd1;
                     max_d = (max_q < 32'd1) ? 32'd1 : max_q;
                     len_d = '0;
                  end else begin
                     state_d = ST_BODY;
                     len_d   = 32'd1;
                  end
               end
            end
            ST_BODY: begin
               if (accept) begin
                  idle_d = timeout_val;
                  len_d  = len_inc;
                  if (tlast_eff) begin
                     pkt_d   = pkt_q + 64'd1;
                     max_d   = (len_inc > max_q) ? len_inc : max_q;
                     state_d = ST_IDLE;
                     len_d   = '0;
                  end else if (len_inc >= MAX_PKT_BEATS) begin
                     // Oversized packet is closed and counted; later beats start afresh.
                     frame_d = 1'b1;
                     pkt_d   = pkt_q + 64'd1;
                     state_d = ST_IDLE;
                     len_d   = '0;
                  end
               end else if (timeout_val != '0) begin
                  if (idle_q <= TIMEOUT_BITS'(1)) begin
                     timeout_d = 1'b1;
                     state_d   = ST_IDLE;
                     len_d     = '0;
                  end else begin
                     idle_d = idle_q - TIMEOUT_BITS'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b0;
         duty_on_q  <= 1'b1;
         duty_cnt_q <= '0;
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idle_q     <= '0;
         beat_q     <= '0;
         pkt_q      <= '0;
         byte_q     <= '0;
         stall_q    <= '0;
         max_q      <= '0;
         frame_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         ready_q    <= ready_d;
         duty_on_q  <= duty_on_d;
         duty_cnt_q <= duty_cnt_d;
         state_q    <= state_d;
         len_q      <= len_d;
         idle_q     <= idle_d;
         beat_q     <= beat_d;
         pkt_q      <= pkt_d;
         byte_q     <= byte_d;
         stall_q    <= stall_d;
         max_q      <= max_d;
         frame_q    <= frame_d;
         timeout_q  <= timeout_d;
      end
   end

   assign s_tready    = ready_q;
   assign beat_cnt    = beat_q;
   assign pkt_cnt     = pkt_q;
   assign byte_cnt    = byte_q;
   assign stall_cnt   = stall_q;
   assign max_pkt_len = max_q;
   assign frame_err   = frame_q;
   assign timeout     = timeout_q;

endmodule

// File: doc/easyobv_axis_sink.md
EASYOBV_AXIS_SINK -- requirements
Module: easyobv_axis_sink

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning:
- DWIDTH, 32, tdata width in bits (multiple of 8).
- HAS_KEEP, 0, tkeep valid; 0 means all bytes valid.
- HAS_LAST, 0, tlast valid; 0 means every beat is a 1-beat packet.
- MAX_PKT_BEATS, 1024, packet length limit before framing error.
- TIMEOUT_BITS, 16, width of the idle-timeout counter and timeout_val.
REQ-002 SHALL have ports, one per line: name direction width meaning:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  DWIDTH  stream data.
- s_tvalid  in  1  stream valid.
- s_tkeep  in  DWIDTH/8  byte qualifiers.
- s_tlast  in  1  end of packet.
- s_tready  out  1  backpressure to the upstream traffic generator.
- enable  in  1  when 0, s_tready=0.
- clear  in  1  synchronous clear of stats and sticky flags.
- ready_mode  in  2  0=always, 1=LFSR random, 2=duty pattern, 3=never.
- ready_thresh  in  8  mode 1: ready when lfsr[7:0] < ready_thresh.
- on_cycles, off_cycles  in  8 each  mode 2: ready high on_cycles, low off_cycles.
- timeout_val  in  TIMEOUT_BITS  mid-packet idle limit; 0 disables.
- beat_cnt, pkt_cnt, byte_cnt, stall_cnt  out  64 each  statistics.
- max_pkt_len  out  32  longest completed packet in beats.
- frame_err, timeout  out  1 each  sticky error flags.

Function
REQ-003 SHALL accept a beat exactly when s_tvalid && s_tready on a rising clk edge.
REQ-004 SHALL register s_tready; it changes only at clk edges and does not depend combinationally on s_tvalid.
REQ-005 SHALL drive s_tready per ready_mode: 0 constant 1; 1 from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1) stepped every cycle; 2 from a duty counter; 3 constant 0.
REQ-006 Duty counter SHALL run on_cycles ready then off_cycles not-ready, repeating. on_cycles=0 SHALL behave as mode 3; off_cycles=0 SHALL behave as mode 0.
REQ-007 Per accepted beat: beat_cnt +1; byte_cnt + popcount(s_tkeep), or + DWIDTH/8 if HAS_KEEP=0.
REQ-008 stall_cnt SHALL increment every cycle with s_tvalid && !s_tready.
REQ-009 FSM states: IDLE, BODY.
- IDLE: accepted beat with tlast -> pkt complete, stay IDLE; without tlast -> BODY, len=1.
- BODY: accepted beat -> len+1; tlast -> pkt complete, go IDLE.
REQ-010 Pkt complete SHALL increment pkt_cnt and set max_pkt_len=max(max_pkt_len, len) in the same cycle. A 1-beat packet has len=1.
REQ-011 In BODY, len reaching MAX_PKT_BEATS without tlast SHALL set frame_err, count one pkt_cnt, and go to IDLE. The next beat starts a new packet.
REQ-012 Idle counter SHALL count BODY cycles with no accepted beat and reset on each accepted beat. Reaching timeout_val (nonzero) SHALL set timeout and go to IDLE without incrementing pkt_cnt.
REQ-013 64-bit counters SHALL wrap modulo 2^64. max_pkt_len SHALL saturate at 2^32-1.
REQ-014 clear SHALL zero all stats and flags, force IDLE and len=0, and take priority over a same-cycle beat, which is not counted. The LFSR and duty counter SHALL NOT be reset by clear.
REQ-015 Stats outputs SHALL be registered and reflect a beat one cycle after acceptance.

Reset
REQ-016 On rst_n=0, asynchronously:
- s_tready=0, all counters=0, flags=0, state=IDLE.
- LFSR=seed, duty counter=0 in its on phase.
REQ-017 Reset assertion mid-packet SHALL discard the partial packet. First possible acceptance is the second clk edge after rst_n deasserts.

Structure
REQ-018 Shared package easyobv_pkg SHALL hold the ready_mode enum, the FSM state enum, and the LFSR seed/taps constants.
REQ-019 SHALL instantiate one sub-module, easyobv_lfsr16: a 16-bit LFSR with step enable and async active-low reset.

Verification
REQ-020 mode 0, 8 beats, tlast on beat 4 and 8, tkeep=4'hF -> pkt_cnt=2, beat_cnt=8, byte_cnt=32, max_pkt_len=4.
REQ-021 mode 2, on=2, off=3, tvalid held high 50 cycles -> s_tready pattern 11000 repeats, stall_cnt=30, beat_cnt=20.
REQ-022 MAX_PKT_BEATS=16, 20 beats with no tlast -> frame_err=1 after beat 16, pkt_cnt=1, state IDLE, beats 17-20 in a new packet.
REQ-023 timeout_val=10, 3 beats with no tlast then tvalid=0 -> timeout=1 on the 10th idle cycle, pkt_cnt unchanged.
REQ-024 clear on the same cycle as an accepted beat -> all stats 0 next cycle, beat not counted.
REQ-025 rst_n pulse mid-packet during mode 1 -> outputs zero immediately, LFSR back to 16'hACE1.
